// File: rtl/edge_capture.sv
// -----------------------------------------------------------------------------
// edge_capture
//    Multi-channel edge detector for asynchronous inputs. Each channel is
//    synchronized, compared with its previous synchronized value, and the
//    edge qualified by a per-channel mode. A qualified edge produces a
//    registered one-cycle pulse, sets a sticky flag and bumps a saturating
//    event counter. After reset release, detection stays masked until the
//    synchronizer and previous-value flop hold real input samples.
//
// Ports
//    clk               system clock, all state on rising edge
//    rst_n             asynchronous active-low reset (release must be
//                      synchronized to clk externally)
//    signal_in[W]      raw asynchronous channel inputs
//    mode[2W]          channel i at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//    clear[W]          synchronous clear of channel sticky flag and counter
//    edge_detect_pulse registered one-cycle pulse per qualified edge
//    edge_sticky       latched edge-seen flag per channel
//    edge_count        channel i count at [(i+1)*CNT_WIDTH-1:i*CNT_WIDTH]
//    count_sat         high while a channel counter is at its maximum
// -----------------------------------------------------------------------------
module edge_capture #(
   parameter int WIDTH       = 2,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           signal_in,
   input  logic [2*WIDTH-1:0]         mode,
   input  logic [WIDTH-1:0]           clear,
   output logic [WIDTH-1:0]           edge_detect_pulse,
   output logic [WIDTH-1:0]           edge_sticky,
   output logic [WIDTH*CNT_WIDTH-1:0] edge_count,
   output logic [WIDTH-1:0]           count_sat
);

   // The arming counter runs 0 .. SYNC_STAGES+1; detection is enabled only
   // once it reaches the top, which hides the artificial edge between the
   // reset-zeroed pipeline and the first real input samples.
   localparam int                   ARM_W    = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0]     ARM_DONE = ARM_W'(SYNC_STAGES + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   logic [ARM_W-1:0] arm_q, arm_d;
   logic             armed;

   always_comb begin
      armed = (arm_q == ARM_DONE);
      arm_d = arm_q;
      if (!armed) begin
         arm_d = arm_q + ARM_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_q <= '0;
      end else begin
         arm_q <= arm_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_q, sync_d;
         logic                   prev_q, prev_d;
         logic                   pulse_q, pulse_d;
         logic                   sticky_q, sticky_d;
         logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
         logic                   s, rise, fall, det;
         logic [1:0]             ch_mode;

         always_comb begin
            sync_d  = {sync_q[SYNC_STAGES-2:0], signal_in[gi]};
            s       = sync_q[SYNC_STAGES-1];
            prev_d  = s;
            rise    = s & ~prev_q;
            fall    = ~s & prev_q;
            ch_mode = mode[2*gi +: 2];
            // Mode gates the edge combinationally; a mode change alone never
            // creates an edge because rise/fall depend only on the input.
            det     = armed & ((ch_mode[0] & rise) | (ch_mode[1] & fall));
            pulse_d = det;
            // Set wins over clear so an edge in the clear cycle is not lost.
            sticky_d = det | (sticky_q & ~clear[gi]);
            if (clear[gi]) begin
               cnt_d = CNT_WIDTH'(det);
            end else if (det && (cnt_q != CNT_MAX)) begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q   <= '0;
               prev_q   <= 1'b0;
               pulse_q  <= 1'b0;
               sticky_q <= 1'b0;
               cnt_q    <= '0;
            end else begin
               sync_q   <= sync_d;
               prev_q   <= prev_d;
               pulse_q  <= pulse_d;
               sticky_q <= sticky_d;
               cnt_q    <= cnt_d;
            end
         end

         assign edge_detect_pulse[gi]                      = pulse_q;
         assign edge_sticky[gi]                            = sticky_q;
         assign edge_count[gi*CNT_WIDTH +: CNT_WIDTH]      = cnt_q;
         assign count_sat[gi]                              = (cnt_q == CNT_MAX);
      end
   endgenerate

endmodule
